// File: rtl/decode_stage.sv
// RV32I decode stage: turns fetched instruction words into decoded packets and
// feeds them into the dispatch queue through a single registered output slot.
`ifndef DE_instr_width
`define DE_instr_width 90
`endif

module decode_stage (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       f_valid,
    output logic                       f_ready,
    input  logic [31:0]                f_instr,
    input  logic [31:0]                f_pc,
    input  logic                       dq_full,
    output logic                       dq_w_en,
    output logic [`DE_instr_width-1:0] dq_instr,
    output logic [15:0]                dec_count
);

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [2:0]  funct3;
        logic        alt;
        logic        rd_we;
        logic        uses_rs1;
        logic        uses_rs2;
        logic        illegal;
    } dec_pkt_t;

    logic     out_valid;
    dec_pkt_t pkt;

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = {{20{f_instr[31]}}, f_instr[31:20]};
    assign imm_s = {{20{f_instr[31]}}, f_instr[31:25], f_instr[11:7]};
    assign imm_b = {{19{f_instr[31]}}, f_instr[31], f_instr[7], f_instr[30:25], f_instr[11:8], 1'b0};
    assign imm_u = {f_instr[31:12], 12'b0};
    assign imm_j = {{11{f_instr[31]}}, f_instr[31], f_instr[19:12], f_instr[20], f_instr[30:21], 1'b0};

    always_comb begin
        pkt          = '0;
        pkt.pc       = f_pc;
        pkt.rd       = f_instr[11:7];
        pkt.rs1      = f_instr[19:15];
        pkt.rs2      = f_instr[24:20];
        pkt.funct3   = f_instr[14:12];
        pkt.cls      = 3'd7;
        case (f_instr[6:0])
            7'b0110011: begin
                pkt.cls      = 3'd0;
                pkt.alt      = f_instr[30];
                pkt.uses_rs1 = 1'b1;
                pkt.uses_rs2 = 1'b1;
                pkt.illegal  = (f_instr[31:25] != 7'b0000000) && (f_instr[31:25] != 7'b0100000);
            end
            7'b0010011: begin
                pkt.cls      = 3'd1;
                pkt.imm      = imm_i;
                pkt.alt      = (f_instr[14:12] == 3'b101) ? f_instr[30] : 1'b0;
                pkt.uses_rs1 = 1'b1;
            end
            7'b0000011: begin
                pkt.cls      = 3'd2;
                pkt.imm      = imm_i;
                pkt.uses_rs1 = 1'b1;
            end
            7'b0100011: begin
                pkt.cls      = 3'd3;
                pkt.imm      = imm_s;
                pkt.uses_rs1 = 1'b1;
                pkt.uses_rs2 = 1'b1;
            end
            7'b1100011: begin
                pkt.cls      = 3'd4;
                pkt.imm      = imm_b;
                pkt.uses_rs1 = 1'b1;
                pkt.uses_rs2 = 1'b1;
            end
            7'b1101111: begin
                pkt.cls      = 3'd5;
                pkt.imm      = imm_j;
            end
            7'b1100111: begin
                pkt.cls      = 3'd5;
                pkt.imm      = imm_i;
                pkt.alt      = 1'b1;
                pkt.uses_rs1 = 1'b1;
            end
            7'b0110111: begin
                pkt.cls      = 3'd6;
                pkt.imm      = imm_u;
            end
            7'b0010111: begin
                pkt.cls      = 3'd6;
                pkt.imm      = imm_u;
                pkt.alt      = 1'b1;
            end
            7'b1110011: pkt.imm = imm_i;
            7'b0001111: pkt.imm = '0;
            default:    pkt.illegal = 1'b1;
        endcase
        pkt.rd_we = (pkt.cls inside {3'd0, 3'd1, 3'd2, 3'd5, 3'd6}) && (pkt.rd != 5'd0);
        // Illegal words still flow to the queue, but stripped of any side effects.
        if (pkt.illegal) begin
            pkt.cls      = 3'd7;
            pkt.imm      = '0;
            pkt.alt      = 1'b0;
            pkt.rd_we    = 1'b0;
            pkt.uses_rs1 = 1'b0;
            pkt.uses_rs2 = 1'b0;
        end
    end

    assign f_ready = rst_n & ~flush & (~out_valid | ~dq_full);
    assign dq_w_en = rst_n & out_valid & ~dq_full & ~flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            dq_instr  <= '0;
            dec_count <= '0;
        end else begin
            if (dq_w_en)
                dec_count <= dec_count + 16'd1;
            // Flush only invalidates; the stale payload is left in place.
            if (flush)
                out_valid <= 1'b0;
            else if (f_valid && f_ready) begin
                dq_instr  <= pkt;
                out_valid <= 1'b1;
            end else if (dq_w_en)
                out_valid <= 1'b0;
        end
    end

endmodule
